pc_gen: RTL and testbench

//  Parametrised PC generator feeding instruction fetch.
//  - Drives the fetch address to inst_rom/icache over a valid/ready handshake.
//  - Honours the pipeline stall vector from ctrl.v.
//  - Takes registered jump redirects from ex.v; a redirect that arrives mid-request is

---
 rtl/pc_gen_pkg.sv | 16 +
 rtl/pc_gen_btb.sv | 58 +++++
 rtl/pc_gen.sv | 138 +++++++++++++
 tb/tb_pc_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the PC generator: FSM encodings, the default
// stall-vector bit owned by fetch, and chip-enable levels.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int STALL_BIT_DEF = 0;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

endpackage

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer for pc_gen.
// Index is pc[IDX_W+1:2]; the tag is the remaining upper bits.
// Lookup is a combinational read of registered entries, so a write and a
// read to the same index in one cycle return the old entry.
module pc_gen_btb #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_src,
  input  logic [ADDR_W-1:0] wr_target,
  output logic              hit,
  output logic [ADDR_W-1:0] target
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [ADDR_W-1:0] tgt_q [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             unused_low_bits;

  assign rd_idx = lookup_pc[IDX_W+1:2];
  assign rd_tag = lookup_pc[ADDR_W-1:IDX_W+2];
  assign wr_idx = wr_src[IDX_W+1:2];
  assign wr_tag = wr_src[ADDR_W-1:IDX_W+2];
  assign unused_low_bits = ^{lookup_pc[1:0], wr_src[1:0]};

  // Valid bits are the only reset state; tags/targets are don't-care until valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and target storage, written on every redirect.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
      tgt_q[wr_idx] <= wr_target;
    end
  end

  assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign target = tgt_q[rd_idx];

endmodule

// File: rtl/pc_gen.sv
// PC generator feeding instruction fetch over a valid/ready handshake.
// Optional BTB prediction is enabled by defining PC_GEN_BTB_EN.
//
// Handshake: fire = req_valid_o & req_ready_i. Once req_valid_o is high it
// stays high with pc_o stable until fire, even if the stall bit rises
// (tracked by outstanding_q). A redirect arriving while a request waits is
// parked in pend_q (state PEND) and applied on fire; with no request in
// flight it lands on pc_o at the next edge.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                STEP      = 4,
  parameter int                CTRL_W    = 6,
  parameter int                STALL_BIT = STALL_BIT_DEF,
  parameter int                BTB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] stall_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_pc_i,
  input  logic [ADDR_W-1:0] jump_src_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              pred_tkn_o,
  output logic [1:0]        state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pend_q;
  logic [ADDR_W-1:0] next_pc;
  logic              ce_q;
  logic              pred_q;
  logic              outstanding_q;
  logic              fire;
  logic              blocked;
  logic              btb_sel;
  logic              btb_hit;
  logic [ADDR_W-1:0] btb_target;
  logic              unused_inputs;

`ifdef PC_GEN_BTB_EN
  pc_gen_btb #(
    .ADDR_W (ADDR_W),
    .DEPTH  (BTB_DEPTH)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .lookup_pc (pc_q),
    .wr_en     (jump_i),
    .wr_src    (jump_src_i),
    .wr_target (jump_pc_i),
    .hit       (btb_hit),
    .target    (btb_target)
  );
  assign unused_inputs = ^stall_i;
`else
  assign btb_hit       = 1'b0;
  assign btb_target    = '0;
  assign unused_inputs = ^{stall_i, jump_src_i, BTB_DEPTH[0]};
`endif

  assign req_valid_o = ce_q & (~stall_i[STALL_BIT] | outstanding_q);
  assign fire        = req_valid_o & req_ready_i;
  assign blocked     = req_valid_o & ~req_ready_i;

  // Next fetch address on fire: pending target, live redirect, BTB, sequential.
  always_comb begin
    next_pc = pc_q + ADDR_W'(STEP);
    btb_sel = 1'b0;
    if (state_q == PEND) begin
      next_pc = pend_q;
    end else if (jump_i) begin
      next_pc = jump_pc_i;
    end else if (btb_hit) begin
      next_pc = btb_target;
      btb_sel = 1'b1;
    end
  end

  // FSM next state: leave BOOT immediately, park redirects that hit a blocked request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (jump_i && blocked) state_d = PEND;
      PEND:    if (fire) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // State register, chip enable and handshake bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      ce_q          <= CHIP_DISABLE;
      outstanding_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ce_q          <= CHIP_ENABLE;
      outstanding_q <= blocked;
    end
  end

  // Pending redirect target; a newer redirect overwrites an older one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else if (jump_i && blocked && (state_q != BOOT)) begin
      pend_q <= jump_pc_i;
    end
  end

  // PC and prediction flag advance together on fire or an idle redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_VEC;
      pred_q <= 1'b0;
    end else if (fire) begin
      pc_q   <= next_pc;
      pred_q <= btb_sel;
    end else if (jump_i && !req_valid_o) begin
      pc_q   <= jump_pc_i;
      pred_q <= 1'b0;
    end
  end

  assign pc_o       = pc_q;
  assign ce_o       = ce_q;
  assign pred_tkn_o = pred_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen. Expected values are hand-computed.
// Inputs change 1 time unit after the rising edge; outputs are compared
// 1 unit later, well away from the next edge.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam logic [31:0] SRC0 = 32'h0000_0F00;
  localparam logic [31:0] SRC1 = 32'h0000_0F04;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        jump;
  logic [31:0] jump_pc;
  logic [31:0] jump_src;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] pc;
  logic        ce;
  logic        pred;
  logic [1:0]  state;

  int n_checks;
  int n_errors;

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall),
    .jump_i      (jump),
    .jump_pc_i   (jump_pc),
    .jump_src_i  (jump_src),
    .req_valid_o (req_valid),
    .req_ready_i (req_ready),
    .pc_o        (pc),
    .ce_o        (ce),
    .pred_tkn_o  (pred),
    .state       (state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = '0; req_ready = 1'b1;
    jump = 1'b0; jump_pc = '0; jump_src = SRC0;
    repeat (2) cyc();
    jump = 1'b1; jump_pc = 32'h500;
    cyc();
    jump = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc actual=%h required=%h", pc, 32'h0); end
    n_checks++; if (ce !== 1'b0) begin n_errors++; $display("FAIL reset_ce actual=%b required=0", ce); end
    n_checks++; if (req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid actual=%b required=0", req_valid); end
    n_checks++; if (pred !== 1'b0) begin n_errors++; $display("FAIL reset_pred actual=%b required=0", pred); end
    n_checks++; if (state !== BOOT) begin n_errors++; $display("FAIL reset_state actual=%0d required=%0d", state, BOOT); end
    rst = 1'b0;
    cyc();
    n_checks++; if (ce !== 1'b1) begin n_errors++; $display("FAIL boot_ce actual=%b required=1", ce); end
    n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL boot_pc actual=%h required=%h", pc, 32'h0); end
    n_checks++; if (req_valid !== 1'b1) begin n_errors++; $display("FAIL boot_valid actual=%b required=1", req_valid); end
    n_checks++; if (state !== RUN) begin n_errors++; $display("FAIL boot_state actual=%0d required=%0d", state, RUN); end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      n_checks++; if (pc !== 32'(4 * i)) begin n_errors++; $display("FAIL seq_pc actual=%h required=%h", pc, 32'(4 * i)); end
    end
  endtask

  task automatic test_stall();
    stall[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (req_valid !== 1'b0) begin n_errors++; $display("FAIL stall_valid actual=%b required=0", req_valid); end
      n_checks++; if (pc !== 32'hC) begin n_errors++; $display("FAIL stall_pc actual=%h required=%h", pc, 32'hC); end
      cyc();
    end
    stall[0] = 1'b0;
    #1;
    n_checks++; if (req_valid !== 1'b1) begin n_errors++; $display("FAIL unstall_valid actual=%b required=1", req_valid); end
    cyc();
    n_checks++; if (pc !== 32'h10) begin n_errors++; $display("FAIL unstall_pc actual=%h required=%h", pc, 32'h10); end
  endtask

  task automatic test_hold();
    req_ready = 1'b0;
    cyc();
    stall[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (req_valid !== 1'b1) begin n_errors++; $display("FAIL hold_valid actual=%b required=1", req_valid); end
      n_checks++; if (pc !== 32'h10) begin n_errors++; $display("FAIL hold_pc actual=%h required=%h", pc, 32'h10); end
      cyc();
    end
    req_ready = 1'b1;
    cyc();
    n_checks++; if (pc !== 32'h14) begin n_errors++; $display("FAIL hold_fire_pc actual=%h required=%h", pc, 32'h14); end
    n_checks++; if (req_valid !== 1'b0) begin n_errors++; $display("FAIL hold_after_valid actual=%b required=0", req_valid); end
    stall[0] = 1'b0;
  endtask

  task automatic test_redirect();
    req_ready = 1'b0; jump = 1'b1; jump_pc = 32'h100;
    cyc();
    jump = 1'b0;
    #1;
    n_checks++; if (state !== PEND) begin n_errors++; $display("FAIL pend_state actual=%0d required=%0d", state, PEND); end
    n_checks++; if (pc !== 32'h14) begin n_errors++; $display("FAIL pend_pc actual=%h required=%h", pc, 32'h14); end
    req_ready = 1'b1;
    cyc();
    n_checks++; if (pc !== 32'h100) begin n_errors++; $display("FAIL pend_fire_pc actual=%h required=%h", pc, 32'h100); end
    n_checks++; if (state !== RUN) begin n_errors++; $display("FAIL pend_exit_state actual=%0d required=%0d", state, RUN); end
    req_ready = 1'b0; jump = 1'b1; jump_pc = 32'h300;
    cyc();
    jump_pc = 32'h200;
    cyc();
    jump = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h100) begin n_errors++; $display("FAIL pend2_pc actual=%h required=%h", pc, 32'h100); end
    req_ready = 1'b1;
    cyc();
    n_checks++; if (pc !== 32'h200) begin n_errors++; $display("FAIL newest_pc actual=%h required=%h", pc, 32'h200); end
    stall[0] = 1'b1;
  endtask

  task automatic test_wrap();
    cyc();
    jump = 1'b1; jump_pc = 32'hFFFF_FFFC; jump_src = SRC1;
    cyc();
    jump = 1'b0; jump_src = SRC0;
    #1;
    n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL idle_jump_pc actual=%h required=%h", pc, 32'hFFFF_FFFC); end
    stall[0] = 1'b0;
    cyc();
    n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL wrap_pc actual=%h required=%h", pc, 32'h0); end
    stall[0] = 1'b1;
  endtask

  task automatic test_btb();
    logic [31:0] exp_pc;
    logic        exp_pred;
    cyc();
    jump = 1'b1; jump_pc = 32'h80; jump_src = 32'h40;
    cyc();
    jump_pc = 32'h40; jump_src = SRC1;
    cyc();
    jump = 1'b0; jump_src = SRC0;
    #1;
    n_checks++; if (pc !== 32'h40) begin n_errors++; $display("FAIL btb_setup_pc actual=%h required=%h", pc, 32'h40); end
    stall[0] = 1'b0;
`ifdef PC_GEN_BTB_EN
    exp_pc = 32'h80; exp_pred = 1'b1;
`else
    exp_pc = 32'h44; exp_pred = 1'b0;
`endif
    cyc();
    n_checks++; if (pc !== exp_pc) begin n_errors++; $display("FAIL btb_pc actual=%h required=%h", pc, exp_pc); end
    n_checks++; if (pred !== exp_pred) begin n_errors++; $display("FAIL btb_pred actual=%b required=%b", pred, exp_pred); end
    exp_pc = exp_pc + 32'h4;
    cyc();
    n_checks++; if (pc !== exp_pc) begin n_errors++; $display("FAIL btb_next_pc actual=%h required=%h", pc, exp_pc); end
    n_checks++; if (pred !== 1'b0) begin n_errors++; $display("FAIL btb_next_pred actual=%b required=0", pred); end
  endtask

  // Test sequence and summary
  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_stall();
    test_hold();
    test_redirect();
    test_wrap();
    test_btb();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
